// File: rtl/mux_ctrl_pkg.sv
// Shared definitions for the two-requester round-robin mux controller.
// The FSM state encoding and the requester select encodings live here.
package mux_ctrl_pkg;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/data_mux2.sv
// Parameterised 2:1 word select; index 0 picks d0 (requester A), 1 picks d1 (B).
module data_mux2 #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              sel,
  input  logic [DATA_W-1:0] d0,
  input  logic [DATA_W-1:0] d1,
  output logic [DATA_W-1:0] y
);

  assign y = sel ? d1 : d0;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter between requesters A and B feeding a one-entry output
// register with a valid/ready handshake downstream.
module mux2_rr_arbiter
  import mux_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_a,
  input  logic [DATA_W-1:0] data_a,
  output logic              gnt_a,
  input  logic              req_b,
  input  logic [DATA_W-1:0] data_b,
  output logic              gnt_b,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              sel
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              sel_q, sel_d;
  logic              last_q, last_d;

  logic              can_load;
  logic              any_req;
  logic              grant;
  logic              win_b;
  logic [DATA_W-1:0] mux_data;

  // B wins when it is the only requester, or on contention when A won last.
  assign win_b    = req_b & (~req_a | (last_q == SEL_A));
  assign any_req  = req_a | req_b;
  assign can_load = (state_q == EMPTY) | (out_valid & out_ready);
  // Gating with rst_n keeps grants low while reset is held.
  assign grant    = rst_n & can_load & any_req;

  assign gnt_a = grant & ~win_b;
  assign gnt_b = grant & win_b;

  data_mux2 #(
    .DATA_W(DATA_W)
  ) u_data_mux2 (
    .sel(win_b),
    .d0 (data_a),
    .d1 (data_b),
    .y  (mux_data)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    last_d  = last_q;
    if (grant) begin
      state_d = FULL;
      data_d  = mux_data;
      sel_d   = win_b;
      last_d  = win_b;
    end else if (can_load) begin
      // Drain with nothing to load: the register empties, payload is kept.
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
      sel_q   <= SEL_A;
      last_q  <= SEL_B;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign sel       = sel_q;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed self-checking bench for mux2_rr_arbiter with hand-computed expectations.
module tb_mux2_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic       req_a, req_b;
  logic [7:0] data_a, data_b;
  logic       gnt_a, gnt_b;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       sel;

  int total = 0;
  int bad   = 0;

  mux2_rr_arbiter #(
    .DATA_W(8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_a    (req_a),
    .data_a   (data_a),
    .gnt_a    (gnt_a),
    .req_b    (req_b),
    .data_b   (data_b),
    .gnt_b    (gnt_b),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .sel      (sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp_b;

    // Reset held with both requests high.
    rst_n = 1'b0; req_a = 1'b1; req_b = 1'b1;
    data_a = 8'hA5; data_b = 8'h5A; out_ready = 1'b1;
    repeat (3) tick();
    check("rst_valid", out_valid, 0);
    check("rst_sel", sel, 0);
    check("rst_data", out_data, 0);
    check("rst_gnt_a", gnt_a, 0);
    check("rst_gnt_b", gnt_b, 0);

    // Release: A wins first contention.
    rst_n = 1'b1;
    #1;
    check("first_gnt_a", gnt_a, 1);
    check("first_gnt_b", gnt_b, 0);
    tick();
    check("first_valid", out_valid, 1);
    check("first_data", out_data, 8'hA5);
    check("first_sel", sel, 0);

    // Continuous contention with ready: alternate B, A, B, A.
    data_a = 8'h11; data_b = 8'h22;
    exp_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("alt_gnt_a", gnt_a, !exp_b);
      check("alt_gnt_b", gnt_b, exp_b);
      tick();
      check("alt_data", out_data, exp_b ? 8'h22 : 8'h11);
      check("alt_sel", sel, exp_b);
      check("alt_valid", out_valid, 1);
      exp_b = !exp_b;
    end

    // Back-pressure for 5 cycles: everything holds, no grants.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_gnt_a", gnt_a, 0);
      check("stall_gnt_b", gnt_b, 0);
      tick();
      check("stall_data", out_data, 8'h11);
      check("stall_sel", sel, 0);
      check("stall_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    #1;
    check("resume_gnt_b", gnt_b, 1);
    check("resume_gnt_a", gnt_a, 0);
    tick();
    check("resume_data", out_data, 8'h22);
    check("resume_sel", sel, 1);

    // Only B requesting for three cycles.
    req_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bonly_gnt_b", gnt_b, 1);
      check("bonly_gnt_a", gnt_a, 0);
      tick();
      check("bonly_sel", sel, 1);
      check("bonly_data", out_data, 8'h22);
    end
    req_a = 1'b1;
    #1;
    check("after_b_gnt_a", gnt_a, 1);
    check("after_b_gnt_b", gnt_b, 0);
    tick();
    check("after_b_data", out_data, 8'h11);
    check("after_b_sel", sel, 0);

    // Drain with no requests: valid clears, payload and sel held.
    req_a = 1'b0; req_b = 1'b0;
    #1;
    check("idle_gnt_a", gnt_a, 0);
    check("idle_gnt_b", gnt_b, 0);
    tick();
    check("drain_valid", out_valid, 0);
    check("drain_data", out_data, 8'h11);
    check("drain_sel", sel, 0);

    // Empty register loads even without ready; last was A so B wins.
    req_a = 1'b1; req_b = 1'b1; out_ready = 1'b0;
    #1;
    check("empty_gnt_b", gnt_b, 1);
    check("empty_gnt_a", gnt_a, 0);
    tick();
    check("empty_valid", out_valid, 1);
    check("empty_data", out_data, 8'h22);

    // Reset mid-transfer while stalled.
    rst_n = 1'b0;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_data", out_data, 0);
    check("midrst_gnt_a", gnt_a, 0);
    check("midrst_gnt_b", gnt_b, 0);
    tick();
    rst_n = 1'b1;
    #1;
    check("post_rst_gnt_a", gnt_a, 1);
    check("post_rst_gnt_b", gnt_b, 0);
    tick();
    check("post_rst_data", out_data, 8'h11);
    check("post_rst_valid", out_valid, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux2_rr_arbiter.md
# mux2_rr_arbiter

Round-robin arbiter and one-entry output register that shares a single downstream channel between two requesters, A and B. It sequences the 2:1 data select, captures the winning word, and presents it downstream with a valid/ready handshake. It sits in front of the shared 2:1 select datapath and owns its select line, which no other block drives.

## Interface

- `DATA_W`, default 8, width of each requester's data word and of the output word.

- `clk`, input, 1, single clock; all state updates on the rising edge.
- `rst_n`, input, 1, asynchronous active-low reset.
- `req_a`, input, 1, requester A has a word on `data_a`; held until `gnt_a`.
- `data_a`, input, `DATA_W`, requester A data; stable while `req_a` is high.
- `gnt_a`, output, 1, combinational; high for exactly the cycle in which `data_a` is captured.
- `req_b`, input, 1, same as `req_a`, for requester B.
- `data_b`, input, `DATA_W`, same as `data_a`, for requester B.
- `gnt_b`, output, 1, same as `gnt_a`, for requester B.
- `out_valid`, output, 1, registered; the output register holds a word.
- `out_data`, output, `DATA_W`, registered; the captured word.
- `out_ready`, input, 1, downstream accepts the word when `out_valid` and `out_ready` are both high.
- `sel`, output, 1, registered; requester of the word currently in the output register (0 = A, 1 = B).

## Operation

- FSM states:
  - `EMPTY`: output register empty.
  - `FULL`: output register holds a word.
- `can_load` = (state == `EMPTY`) OR (`out_valid` AND `out_ready`).
- Arbitration is evaluated only when `can_load` is high:
  - Only `req_a` high: A wins.
  - Only `req_b` high: B wins.
  - Both high: the requester not equal to `last` wins.
  - Neither high: no grant.
- On a win:
  - Assert `gnt_x` combinationally in that cycle.
  - On the clock edge: `out_data` <= `data_x`, `sel` <= x, `last` <= x, state <= `FULL`.
- If `can_load` is high but there is no request:
  - A drain in progress moves the state to `EMPTY` and clears `out_valid`.
  - `out_data` and `sel` keep their old values.
- In `FULL` without `out_ready`:
  - Hold `out_data` and `sel`.
  - Both grants stay low.
  - Requests wait.
- `gnt_a` and `gnt_b` are never high in the same cycle.
- A requester's grant is never asserted while its `req` is low.
- `last` is an internal 1-bit round-robin pointer, updated only on a grant.
- Reset values:
  - State `EMPTY`, `out_valid` 0, `out_data` 0, `sel` 0.
  - `last` = 1 (B), so A wins the first contention.
  - `gnt_a` and `gnt_b` are 0 whenever `rst_n` is low.
- Reset asserted mid-transfer: the held word is discarded and no grant is issued. After release, normal operation resumes from reset values.

## Timing

- Latency: request cycle with grant → `out_valid` high on the next edge, i.e. 1 cycle.
- Throughput: one word per cycle while `out_ready` is held high and requests are pending.
- Drain and load in the same cycle: `out_valid` stays high, and the new word replaces the old one on the edge.
- Fairness:
  - Under continuous contention, grants alternate A, B, A, B…
  - Worst-case wait for a pending requester is one other grant, assuming downstream makes progress.
- `out_valid`, `out_data` and `sel` never change while `out_valid` is high and `out_ready` is low.
- No combinational path exists from `out_ready` to `out_valid` or `out_data`. A path from `out_ready` to the grants is permitted.

## Structure

- Shared package `mux_ctrl_pkg`:
  - State enum `{EMPTY, FULL}`.
  - Select encodings `SEL_A = 1'b0`, `SEL_B = 1'b1`.
- Sub-module `data_mux2`:
  - Parameterised `DATA_W`-wide 2:1 select.
  - Driven by the winner index; feeds the output register.
- Arbiter, FSM and output register live in the top module.

## Test plan

- Reset with both requests high throughout:
  - During reset: `out_valid` = 0, `sel` = 0, no grants.
  - First cycle after release: `gnt_a` = 1.
  - Next edge: `out_data` = `data_a` (e.g. 8'hA5), `out_valid` = 1.
- Both requesters continuously high, `out_ready` = 1, `data_a` = 8'h11, `data_b` = 8'h22:
  - Output stream is 11, 22, 11, 22.
  - Grants alternate each cycle, one word per cycle.
- `out_ready` = 0 for 5 cycles with `out_valid` high:
  - `out_data` and `sel` stay constant, both grants stay 0.
  - When `out_ready` returns to 1, the pending request is granted in that same cycle.
- Only `req_b` high for 3 cycles with `out_ready` = 1:
  - Three B grants, `sel` = 1.
  - Then assert both requests: A wins, because `last` = B.
- Assert `rst_n` low while `out_valid` = 1 and `out_ready` = 0:
  - `out_valid` drops immediately (asynchronously) and no grant is issued.
  - After release, the first contention goes to A.
